// File: rtl/dip_debouncer_pkg.sv
// Shared types and defaults for the DIP-switch debouncer.
// The optional per-bit change pulse is enabled with DIP_DEBOUNCE_EDGE_EN.
package dip_pkg;

  localparam int DIP_WIDTH           = 4;
  localparam int DIP_DEBOUNCE_CYCLES = 24000;

  typedef enum logic {
    DB_IDLE  = 1'b0,
    DB_COUNT = 1'b1
  } db_state_t;

endpackage

// File: rtl/dip_debouncer_if.sv
// Switch-bank interface: raw levels in, debounced levels and status out.
// The changed vector exists only when DIP_DEBOUNCE_EDGE_EN is defined.
interface dip_debouncer_if
  import dip_pkg::*;
#(
  parameter int WIDTH = DIP_WIDTH
);

  logic [WIDTH-1:0] sw_raw;
  logic [WIDTH-1:0] data;
  logic             settled;
`ifdef DIP_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] changed;
`endif

  modport master (
    output sw_raw,
    input  data,
`ifdef DIP_DEBOUNCE_EDGE_EN
    input  changed,
`endif
    input  settled
  );

  modport slave (
    input  sw_raw,
    output data,
`ifdef DIP_DEBOUNCE_EDGE_EN
    output changed,
`endif
    output settled
  );

endinterface

// File: rtl/dip_debouncer_debounce_bit.sv
// One switch bit: 2-flop synchroniser, then a stability counter FSM.
// With DIP_DEBOUNCE_EDGE_EN a one-cycle changed pulse accompanies each update.
module debounce_bit
  import dip_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic nreset,
  input  logic sw_raw,
  output logic data,
`ifdef DIP_DEBOUNCE_EDGE_EN
  output logic changed,
`endif
  output logic idle
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1_q, s1_d;
  logic             s2_q, s2_d;
  logic             data_q, data_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  db_state_t        state_q, state_d;
  logic             take;

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    s1_d    = sw_raw;
    s2_d    = s1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    take    = 1'b0;

    case (state_q)
      DB_IDLE: begin
        cnt_d = '0;
        if (s2_q != data_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            take = 1'b1;
          end else begin
            state_d = DB_COUNT;
            cnt_d   = CNT_ONE;
          end
        end
      end
      DB_COUNT: begin
        if (s2_q == data_q) begin
          // Level went back before the window closed: glitch, drop it.
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          take    = 1'b1;
          state_d = DB_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
    endcase

    data_d = take ? s2_q : data_q;
  end

  // NOTE: state is updated with <= so every flop samples the pre-edge values; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!nreset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      data_q  <= 1'b0;
      cnt_q   <= '0;
      state_q <= DB_IDLE;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef DIP_DEBOUNCE_EDGE_EN
  logic changed_q, changed_d;

  always_comb begin
    changed_d = take;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;
`endif

  assign data = data_q;
  assign idle = (state_q == DB_IDLE);

endmodule

// File: rtl/dip_debouncer.sv
// Debounces a WIDTH-bit DIP-switch bank, one independent debounce_bit per switch.
// Define DIP_DEBOUNCE_EDGE_EN to add the per-bit changed pulse output.
module dip_debouncer
  import dip_pkg::*;
#(
  parameter int WIDTH           = DIP_WIDTH,
  parameter int DEBOUNCE_CYCLES = DIP_DEBOUNCE_CYCLES
) (
  input logic             clk,
  input logic             nreset,
  dip_debouncer_if.slave  bus
);

  logic [WIDTH-1:0] data_w;
  logic [WIDTH-1:0] idle_w;
`ifdef DIP_DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] changed_w;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .nreset (nreset),
      .sw_raw (bus.sw_raw[i]),
      .data   (data_w[i]),
`ifdef DIP_DEBOUNCE_EDGE_EN
      .changed(changed_w[i]),
`endif
      .idle   (idle_w[i])
    );
  end

  assign bus.data    = data_w;
  assign bus.settled = &idle_w;
`ifdef DIP_DEBOUNCE_EDGE_EN
  assign bus.changed = changed_w;
`endif

endmodule
